// File: rtl/mem_access.sv
// ============================================================================
// Module   : mem_access
// Brief    : MEM stage - byte/word loads and stores over a req/ack data bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access #(
   parameter logic [7:0] LB_OP  = 8'b11100000,
   parameter logic [7:0] LBU_OP = 8'b11100100,
   parameter logic [7:0] LW_OP  = 8'b11100011,
   parameter logic [7:0] SB_OP  = 8'b11101000,
   parameter logic [7:0] SW_OP  = 8'b11101011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid_i,
   input  logic [7:0]  ex_aluop_i,
   input  logic [31:0] ex_mem_addr_i,
   input  logic [31:0] ex_reg2_i,
   input  logic [4:0]  ex_wd_i,
   input  logic        ex_wreg_i,
   input  logic [31:0] ex_wdata_i,
   output logic        stallreq_o,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [3:0]  dbus_sel_o,
   output logic [31:0] dbus_wdata_o,
   input  logic        dbus_ack_i,
   input  logic [31:0] dbus_rdata_i,
   output logic        wb_valid_o,
   output logic [4:0]  wb_wd_o,
   output logic        wb_wreg_o,
   output logic [31:0] wb_wdata_o,
   output logic        addr_err_o
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUS  = 1'b1
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_we, w_we_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic [3:0]  r_sel, w_sel_nxt;
   logic [31:0] r_wdata, w_wdata_nxt;
   logic [7:0]  r_op, w_op_nxt;
   logic [1:0]  r_lane, w_lane_nxt;
   logic [4:0]  r_bus_wd, w_bus_wd_nxt;
   logic        r_wb_valid, w_wb_valid_nxt;
   logic [4:0]  r_wb_wd, w_wb_wd_nxt;
   logic        r_wb_wreg, w_wb_wreg_nxt;
   logic [31:0] r_wb_wdata, w_wb_wdata_nxt;
   logic        r_addr_err, w_addr_err_nxt;

   logic        w_is_load, w_is_store, w_is_word, w_misalign;
   logic        w_r_is_load;
   logic [7:0]  w_byte;
   logic [31:0] w_load_data;

   assign w_is_load  = (ex_aluop_i == LB_OP) || (ex_aluop_i == LBU_OP) || (ex_aluop_i == LW_OP);
   assign w_is_store = (ex_aluop_i == SB_OP) || (ex_aluop_i == SW_OP);
   assign w_is_word  = (ex_aluop_i == LW_OP) || (ex_aluop_i == SW_OP);
   assign w_misalign = w_is_word && (ex_mem_addr_i[1:0] != 2'b00);

   assign w_r_is_load = (r_op == LB_OP) || (r_op == LBU_OP) || (r_op == LW_OP);

   // Big-endian lanes: lane 0 is the most significant byte of the bus word.
   always_comb begin
      w_byte = 8'h00;
      case (r_lane)
         2'd0:    w_byte = dbus_rdata_i[31:24];
         2'd1:    w_byte = dbus_rdata_i[23:16];
         2'd2:    w_byte = dbus_rdata_i[15:8];
         default: w_byte = dbus_rdata_i[7:0];
      endcase
   end

   always_comb begin
      w_load_data = dbus_rdata_i;
      if (r_op == LB_OP)
         w_load_data = {{24{w_byte[7]}}, w_byte};
      else if (r_op == LBU_OP)
         w_load_data = {24'h000000, w_byte};
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_we_nxt       = r_we;
      w_addr_nxt     = r_addr;
      w_sel_nxt      = r_sel;
      w_wdata_nxt    = r_wdata;
      w_op_nxt       = r_op;
      w_lane_nxt     = r_lane;
      w_bus_wd_nxt   = r_bus_wd;
      w_wb_valid_nxt = 1'b0;
      w_wb_wd_nxt    = r_wb_wd;
      w_wb_wreg_nxt  = 1'b0;
      w_wb_wdata_nxt = r_wb_wdata;
      w_addr_err_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (ex_valid_i) begin
               if (w_misalign) begin
                  w_wb_valid_nxt = 1'b1;
                  w_addr_err_nxt = 1'b1;
               end else if (w_is_load || w_is_store) begin
                  w_state_nxt  = S_BUS;
                  w_we_nxt     = w_is_store;
                  w_addr_nxt   = {ex_mem_addr_i[31:2], 2'b00};
                  w_sel_nxt    = w_is_word ? 4'b1111 : (4'b1000 >> ex_mem_addr_i[1:0]);
                  w_op_nxt     = ex_aluop_i;
                  w_lane_nxt   = ex_mem_addr_i[1:0];
                  w_bus_wd_nxt = ex_wd_i;
                  if (ex_aluop_i == SW_OP)
                     w_wdata_nxt = ex_reg2_i;
                  else if (ex_aluop_i == SB_OP)
                     w_wdata_nxt = {4{ex_reg2_i[7:0]}};
                  else
                     w_wdata_nxt = 32'h0;
               end else begin
                  w_wb_valid_nxt = 1'b1;
                  w_wb_wd_nxt    = ex_wd_i;
                  w_wb_wreg_nxt  = ex_wreg_i;
                  w_wb_wdata_nxt = ex_wdata_i;
               end
            end
         end
         S_BUS: begin
            if (dbus_ack_i) begin
               w_state_nxt    = S_IDLE;
               w_wb_valid_nxt = 1'b1;
               if (w_r_is_load) begin
                  w_wb_wreg_nxt  = 1'b1;
                  w_wb_wd_nxt    = r_bus_wd;
                  w_wb_wdata_nxt = w_load_data;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_we       <= 1'b0;
         r_addr     <= 32'h0;
         r_sel      <= 4'h0;
         r_wdata    <= 32'h0;
         r_op       <= 8'h0;
         r_lane     <= 2'd0;
         r_bus_wd   <= 5'd0;
         r_wb_valid <= 1'b0;
         r_wb_wd    <= 5'd0;
         r_wb_wreg  <= 1'b0;
         r_wb_wdata <= 32'h0;
         r_addr_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_we       <= w_we_nxt;
         r_addr     <= w_addr_nxt;
         r_sel      <= w_sel_nxt;
         r_wdata    <= w_wdata_nxt;
         r_op       <= w_op_nxt;
         r_lane     <= w_lane_nxt;
         r_bus_wd   <= w_bus_wd_nxt;
         r_wb_valid <= w_wb_valid_nxt;
         r_wb_wd    <= w_wb_wd_nxt;
         r_wb_wreg  <= w_wb_wreg_nxt;
         r_wb_wdata <= w_wb_wdata_nxt;
         r_addr_err <= w_addr_err_nxt;
      end
   end

   // Request and stall are pure state decodes so reset drops them at once.
   assign stallreq_o   = (r_state == S_BUS);
   assign dbus_req_o   = (r_state == S_BUS);
   assign dbus_we_o    = r_we;
   assign dbus_addr_o  = r_addr;
   assign dbus_sel_o   = r_sel;
   assign dbus_wdata_o = r_wdata;
   assign wb_valid_o   = r_wb_valid;
   assign wb_wd_o      = r_wb_wd;
   assign wb_wreg_o    = r_wb_wreg;
   assign wb_wdata_o   = r_wb_wdata;
   assign addr_err_o   = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module   : tb_mem_access
// Brief    : Self-checking bench for mem_access against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;

   localparam logic [7:0] C_LB  = 8'b11100000;
   localparam logic [7:0] C_LBU = 8'b11100100;
   localparam logic [7:0] C_LW  = 8'b11100011;
   localparam logic [7:0] C_SB  = 8'b11101000;
   localparam logic [7:0] C_SW  = 8'b11101011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid_i = 1'b0;
   logic [7:0]  ex_aluop_i = 8'h0;
   logic [31:0] ex_mem_addr_i = 32'h0;
   logic [31:0] ex_reg2_i = 32'h0;
   logic [4:0]  ex_wd_i = 5'd0;
   logic        ex_wreg_i = 1'b0;
   logic [31:0] ex_wdata_i = 32'h0;
   logic        dbus_ack_i = 1'b0;
   logic [31:0] dbus_rdata_i = 32'h0;
   logic        stallreq_o, dbus_req_o, dbus_we_o;
   logic [31:0] dbus_addr_o, dbus_wdata_o, wb_wdata_o;
   logic [3:0]  dbus_sel_o;
   logic        wb_valid_o, wb_wreg_o, addr_err_o;
   logic [4:0]  wb_wd_o;

   int n_assert = 0;
   int n_fail   = 0;
   int req_cnt  = 0;

   mem_access dut (
      .clk          (clk),
      .rst          (rst),
      .ex_valid_i   (ex_valid_i),
      .ex_aluop_i   (ex_aluop_i),
      .ex_mem_addr_i(ex_mem_addr_i),
      .ex_reg2_i    (ex_reg2_i),
      .ex_wd_i      (ex_wd_i),
      .ex_wreg_i    (ex_wreg_i),
      .ex_wdata_i   (ex_wdata_i),
      .stallreq_o   (stallreq_o),
      .dbus_req_o   (dbus_req_o),
      .dbus_we_o    (dbus_we_o),
      .dbus_addr_o  (dbus_addr_o),
      .dbus_sel_o   (dbus_sel_o),
      .dbus_wdata_o (dbus_wdata_o),
      .dbus_ack_i   (dbus_ack_i),
      .dbus_rdata_i (dbus_rdata_i),
      .wb_valid_o   (wb_valid_o),
      .wb_wd_o      (wb_wd_o),
      .wb_wreg_o    (wb_wreg_o),
      .wb_wdata_o   (wb_wdata_o),
      .addr_err_o   (addr_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding access, expected write-back.
   logic        m_busy = 1'b0;
   logic [31:0] m_addr = 32'h0;
   logic [3:0]  m_sel = 4'h0;
   logic        m_we = 1'b0;
   logic [31:0] m_wdata = 32'h0;
   logic [7:0]  m_op = 8'h0;
   logic [1:0]  m_lane = 2'd0;
   logic [4:0]  m_wd = 5'd0;
   logic        e_valid = 1'b0, e_wreg = 1'b0, e_err = 1'b0, e_chk = 1'b0;
   logic [4:0]  e_wd = 5'd0;
   logic [31:0] e_wdata = 32'h0;

   always @(posedge clk or posedge rst) begin
      logic        is_word, is_mem;
      logic [31:0] sh;
      logic [7:0]  b;
      e_valid = 1'b0;
      e_wreg  = 1'b0;
      e_err   = 1'b0;
      e_chk   = 1'b0;
      if (rst) begin
         m_busy = 1'b0;
      end else if (!m_busy) begin
         if (ex_valid_i) begin
            is_word = (ex_aluop_i == C_LW) || (ex_aluop_i == C_SW);
            is_mem  = is_word || (ex_aluop_i == C_LB) || (ex_aluop_i == C_LBU) || (ex_aluop_i == C_SB);
            if (is_word && ex_mem_addr_i[1:0] != 2'b00) begin
               e_valid = 1'b1;
               e_err   = 1'b1;
            end else if (is_mem) begin
               m_busy  = 1'b1;
               m_op    = ex_aluop_i;
               m_lane  = ex_mem_addr_i[1:0];
               m_addr  = ex_mem_addr_i & 32'hFFFF_FFFC;
               m_we    = (ex_aluop_i == C_SB) || (ex_aluop_i == C_SW);
               m_sel   = is_word ? 4'hF : (4'h8 >> m_lane);
               m_wd    = ex_wd_i;
               m_wdata = (ex_aluop_i == C_SW) ? ex_reg2_i :
                         (ex_aluop_i == C_SB) ? ex_reg2_i[7:0] * 32'h01010101 : 32'h0;
            end else begin
               e_valid = 1'b1;
               e_wreg  = ex_wreg_i;
               e_wd    = ex_wd_i;
               e_wdata = ex_wdata_i;
               e_chk   = 1'b1;
            end
         end
      end else if (dbus_ack_i) begin
         m_busy  = 1'b0;
         e_valid = 1'b1;
         if (!m_we) begin
            sh = dbus_rdata_i >> (8 * (3 - m_lane));
            b  = sh[7:0];
            e_wreg = 1'b1;
            e_wd   = m_wd;
            e_chk  = 1'b1;
            if (m_op == C_LW)      e_wdata = dbus_rdata_i;
            else if (m_op == C_LB) e_wdata = (b >= 8'h80) ? 32'hFFFFFF00 + b : {24'h0, b};
            else                   e_wdata = {24'h0, b};
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (dbus_req_o) req_cnt++;
         chk("stallreq", {31'h0, stallreq_o}, {31'h0, m_busy});
         chk("dbus_req", {31'h0, dbus_req_o}, {31'h0, m_busy});
         chk("wb_valid", {31'h0, wb_valid_o}, {31'h0, e_valid});
         chk("wb_wreg", {31'h0, wb_wreg_o}, {31'h0, e_wreg});
         chk("addr_err", {31'h0, addr_err_o}, {31'h0, e_err});
         if (m_busy) begin
            chk("dbus_addr", dbus_addr_o, m_addr);
            chk("dbus_sel", {28'h0, dbus_sel_o}, {28'h0, m_sel});
            chk("dbus_we", {31'h0, dbus_we_o}, {31'h0, m_we});
            chk("dbus_wdata", dbus_wdata_o, m_wdata);
         end
         if (e_chk) begin
            chk("wb_wd", {27'h0, wb_wd_o}, {27'h0, e_wd});
            chk("wb_wdata", wb_wdata_o, e_wdata);
         end
      end
   end

   // Callers are 1ns past a rising edge; the op is captured at the next edge.
   task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
      ex_valid_i    = 1'b1;
      ex_aluop_i    = op;
      ex_mem_addr_i = addr;
      ex_reg2_i     = reg2;
      ex_wd_i       = wd;
      ex_wreg_i     = wreg;
      ex_wdata_i    = wdata;
      @(posedge clk); #1;
      ex_valid_i    = 1'b0;
   endtask

   task automatic reply(input int waits, input logic [31:0] rd);
      repeat (waits) begin
         @(posedge clk); #1;
      end
      dbus_ack_i   = 1'b1;
      dbus_rdata_i = rd;
      @(posedge clk); #1;
      dbus_ack_i   = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb_valid", {31'h0, wb_valid_o}, 32'h0);
      chk("rst_req", {31'h0, dbus_req_o}, 32'h0);
      chk("rst_stall", {31'h0, stallreq_o}, 32'h0);
      chk("rst_wb_wreg", {31'h0, wb_wreg_o}, 32'h0);
      chk("rst_addr_err", {31'h0, addr_err_o}, 32'h0);
      chk("rst_dbus_addr", dbus_addr_o, 32'h0);
      rst = 1'b0;

      // Passthrough, captured on the very first edge after reset release.
      req_cnt = 0;
      issue(8'h20, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
      @(negedge clk);
      chk("pass_valid", {31'h0, wb_valid_o}, 32'h1);
      chk("pass_wd", {27'h0, wb_wd_o}, 32'd5);
      chk("pass_wdata", wb_wdata_o, 32'h1234);
      chk("pass_noreq", req_cnt, 0);
      @(posedge clk); #1;

      // LW with ack on 2nd bus cycle; a stray EX result during BUS is ignored.
      req_cnt = 0;
      issue(C_LW, 32'h100, 32'h0, 5'd9, 1'b1, 32'h0);
      ex_valid_i = 1'b1; ex_aluop_i = 8'h20; ex_wd_i = 5'd7; ex_wdata_i = 32'h99;
      @(negedge clk);
      chk("lw_sel", {28'h0, dbus_sel_o}, 32'hF);
      @(posedge clk); #1;
      ex_valid_i = 1'b0;
      reply(0, 32'hDEADBEEF);
      @(negedge clk);
      chk("lw_req_cycles", req_cnt, 2);
      chk("lw_wdata", wb_wdata_o, 32'hDEADBEEF);
      chk("lw_wreg", {31'h0, wb_wreg_o}, 32'h1);
      @(posedge clk); #1;

      // LB then back-to-back LBU (zero-wait, 3-cycle cadence).
      issue(C_LB, 32'h102, 32'h0, 5'd3, 1'b1, 32'h0);
      @(negedge clk);
      chk("lb_sel", {28'h0, dbus_sel_o}, 32'h2);
      @(posedge clk); #1;
      reply(0, 32'h0011F0FF);
      @(negedge clk);
      chk("lb_wdata", wb_wdata_o, 32'hFFFFFFF0);
      @(posedge clk); #1;
      issue(C_LBU, 32'h102, 32'h0, 5'd4, 1'b1, 32'h0);
      reply(0, 32'h0011F0FF);
      @(negedge clk);
      chk("lbu_wdata", wb_wdata_o, 32'h000000F0);
      @(posedge clk); #1;
      issue(C_LB, 32'h300, 32'h0, 5'd6, 1'b1, 32'h0);
      reply(1, 32'h7F8000AA);
      @(posedge clk); #1;

      // SB to the lowest lane.
      issue(C_SB, 32'h203, 32'h000000AB, 5'd1, 1'b1, 32'h0);
      @(negedge clk);
      chk("sb_we", {31'h0, dbus_we_o}, 32'h1);
      chk("sb_addr", dbus_addr_o, 32'h200);
      chk("sb_sel", {28'h0, dbus_sel_o}, 32'h1);
      chk("sb_wdata", dbus_wdata_o, 32'hABABABAB);
      @(posedge clk); #1;
      reply(0, 32'h0);
      @(negedge clk);
      chk("sb_wreg", {31'h0, wb_wreg_o}, 32'h0);
      @(posedge clk); #1;

      // Aligned SW, then misaligned SW.
      issue(C_SW, 32'h40, 32'hCAFEF00D, 5'd2, 1'b0, 32'h0);
      reply(2, 32'h0);
      @(posedge clk); #1;
      req_cnt = 0;
      issue(C_SW, 32'h102, 32'h55, 5'd2, 1'b0, 32'h0);
      @(negedge clk);
      chk("mis_err", {31'h0, addr_err_o}, 32'h1);
      chk("mis_valid", {31'h0, wb_valid_o}, 32'h1);
      chk("mis_wreg", {31'h0, wb_wreg_o}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_noreq", req_cnt, 0);

      // Ack while idle is ignored.
      @(posedge clk); #1;
      dbus_ack_i = 1'b1;
      @(posedge clk); #1;
      dbus_ack_i = 1'b0;

      // Reset mid-access.
      issue(C_LW, 32'h500, 32'h0, 5'd8, 1'b1, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rstmid_req", {31'h0, dbus_req_o}, 32'h0);
      chk("rstmid_stall", {31'h0, stallreq_o}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      dbus_ack_i = 1'b1;
      dbus_rdata_i = 32'h12345678;
      @(posedge clk); #1;
      dbus_ack_i = 1'b0;
      @(negedge clk);
      chk("rstmid_nowb", {31'h0, wb_valid_o}, 32'h0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
- REQ-001: Parameter LB_OP, 8'b11100000, aluop code of load byte (sign-extended).
- REQ-002: Parameter LBU_OP, 8'b11100100, aluop code of load byte (zero-extended).
- REQ-003: Parameter LW_OP, 8'b11100011, aluop code of load word.
- REQ-004: Parameter SB_OP, 8'b11101000, aluop code of store byte.
- REQ-005: Parameter SW_OP, 8'b11101011, aluop code of store word.
- REQ-006: Clocking SHALL be one clock, clk; reset rst SHALL be asynchronous and active-high.
- REQ-007: Ports (name, direction, width, meaning):
  - clk  in  1  clock.
  - rst  in  1  async reset, active-high.
  - ex_valid_i  in  1  EX result valid.
  - ex_aluop_i  in  8  operation code.
  - ex_mem_addr_i  in  32  effective address.
  - ex_reg2_i  in  32  store data.
  - ex_wd_i  in  5  destination register.
  - ex_wreg_i  in  1  write enable.
  - ex_wdata_i  in  32  ALU result.
  - stallreq_o  out  1  hold EX stage.
  - dbus_req_o  out  1  bus request.
  - dbus_we_o  out  1  bus write.
  - dbus_addr_o  out  32  word address, bits [1:0] = 0.
  - dbus_sel_o  out  4  byte-lane enables.
  - dbus_wdata_o  out  32  write data.
  - dbus_ack_i  in  1  bus transfer complete.
  - dbus_rdata_i  in  32  read data.
  - wb_valid_o  out  1  write-back entry valid.
  - wb_wd_o  out  5  write-back register.
  - wb_wreg_o  out  1  write-back enable.
  - wb_wdata_o  out  32  write-back data.
  - addr_err_o  out  1  misalignment flag, one-cycle pulse.

Function
- REQ-008: FSM states SHALL be IDLE and BUS; stallreq_o SHALL equal 1 exactly while in BUS.
- REQ-009: In IDLE at a clk edge with ex_valid_i=1:
  - Non-memory op: load ex_wd_i, ex_wreg_i and ex_wdata_i into wb_*; set wb_valid_o=1 (latency 1 cycle).
  - Aligned memory op: latch bus fields, enter BUS, drive wb_valid_o=0.
- REQ-010: In IDLE with ex_valid_i=0, the next edge SHALL drive wb_valid_o=0 and wb_wreg_o=0.
- REQ-011: Bus byte lanes SHALL be big-endian: addr[1:0]=0 selects bits [31:24], addr[1:0]=3 selects bits [7:0].
- REQ-012: dbus_sel_o SHALL be 4'b1111 for LW/SW and 4'b1000>>addr[1:0] for LB/LBU/SB.
- REQ-013: For SB, dbus_wdata_o SHALL be {4{reg2[7:0]}}; for SW, reg2; for loads, 0.
- REQ-014: In BUS, dbus_req_o=1, and addr, sel, we and wdata SHALL be held stable until the edge where dbus_ack_i=1.
- REQ-015: At the ack edge, FSM SHALL return to IDLE and set wb_valid_o=1 for one cycle:
  - Loads: wb_wreg_o=1, wb_wd_o=latched wd, wb_wdata_o=extracted value.
  - Stores: wb_wreg_o=0.
- REQ-016: Load extraction:
  - LW: dbus_rdata_i.
  - LB: selected byte sign-extended to 32 bits.
  - LBU: selected byte zero-extended to 32 bits.
- REQ-017: The cycle after the ack edge is IDLE with stallreq_o=0; a new EX result SHALL be accepted at the end of that cycle, giving a minimum of 3 cycles per memory op with zero-wait ack.
- REQ-018: A misaligned LW/SW (addr[1:0]!=0) SHALL issue no bus request; the next edge SHALL give wb_valid_o=1, wb_wreg_o=0, addr_err_o=1 for one cycle, and the state SHALL stay IDLE.
- REQ-019: dbus_ack_i SHALL be ignored in IDLE.
- REQ-020: While in BUS, ex_* inputs SHALL be ignored.
- REQ-021: All outputs except stallreq_o and dbus_req_o SHALL be registered; stallreq_o and dbus_req_o SHALL decode the state register only.

Reset
- REQ-022: On rst=1, asynchronously: state=IDLE, and every output = 0, including dbus_req_o, stallreq_o, wb_valid_o, wb_wreg_o and addr_err_o.
- REQ-023: Reset during BUS SHALL abandon the transfer with no write-back, and a later ack SHALL be ignored.
- REQ-024: The first capture after rst deasserts SHALL occur at the first clk edge with rst=0.

Verification
- REQ-025: Add passthrough:
  - Stimulus: ex_valid_i=1, aluop=8'h20, wd=5, wreg=1, wdata=32'h1234.
  - Response: next cycle wb_valid_o=1, wb_wd_o=5, wb_wdata_o=32'h1234; no dbus_req_o.
- REQ-026: LW with 2-cycle wait:
  - Stimulus: LW, addr=32'h100, ack asserted on the 2nd BUS cycle, rdata=32'hDEADBEEF.
  - Response: req high for 2 cycles, sel=4'b1111, stallreq_o high for 2 cycles, then wb_wdata_o=32'hDEADBEEF with wb_wreg_o=1.
- REQ-027: LB / LBU:
  - Stimulus: LB, addr=32'h102, rdata=32'h0011F0FF.
  - Response: sel=4'b0010, wb_wdata_o=32'hFFFFFFF0; with LBU, wb_wdata_o=32'h000000F0.
- REQ-028: SB:
  - Stimulus: SB, addr=32'h203, reg2=32'h000000AB.
  - Response: dbus_we_o=1, dbus_addr_o=32'h200, sel=4'b0001, wdata=32'hABABABAB, wb_wreg_o=0.
- REQ-029: Misaligned SW:
  - Stimulus: SW, addr=32'h102.
  - Response: no req; next cycle addr_err_o=1, wb_valid_o=1, wb_wreg_o=0.
- REQ-030: Reset mid-access:
  - Stimulus: LW held in BUS with no ack; assert rst.
  - Response: dbus_req_o=0 and stallreq_o=0 immediately; no write-back after release.
